// File: rtl/vsd_dac_pkg.sv
// Shared types and helpers for the DAC stream sequencer.
package vsd_dac_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_MUTE   = 2'd2,
    MODE_RAMP   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_e;

  // Mid-range code of an unsigned DAC of the given width.
  function automatic logic [31:0] midscale(input int unsigned data_w);
    return 32'd1 << (data_w - 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo_fl.sv
// Single-clock FIFO with occupancy output and synchronous flush; show-ahead read port.
module sync_fifo_fl #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_nxt;
  logic             full_q;
  logic             empty_q;
  logic             do_push_c;
  logic             do_pop_c;

  // Full gates push even with a same-cycle pop; flush discards both.
  assign do_push_c = push && !full_q && !flush;
  assign do_pop_c  = pop && !empty_q && !flush;

  always_comb begin
    level_nxt = level_q;
    if (flush) begin
      level_nxt = '0;
    end else if (do_push_c && !do_pop_c) begin
      level_nxt = level_q + LW'(1);
    end else if (!do_push_c && do_pop_c) begin
      level_nxt = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      level_q <= level_nxt;
      full_q  <= (level_nxt == LW'(DEPTH));
      empty_q <= (level_nxt == '0);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

endmodule

// File: rtl/dac_stream_sequencer.sv
// Buffers channel-tagged core samples and releases them to per-channel DAC hold
// registers at a programmable rate, with hold, mute and ramp-test modes.
module dac_stream_sequencer
  import vsd_dac_pkg::*;
#(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned PRIME_LVL  = 4,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [CH_W-1:0]          s_ch,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [DIV_W-1:0]         rate_div,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic [NUM_CH*DATA_W-1:0] dac_d,
  output logic [NUM_CH-1:0]        dac_upd,
  output logic [LVL_W-1:0]         fifo_level,
  output logic                     underrun,
  output logic                     err_ch
);

  localparam int unsigned ENT_W = CH_W + DATA_W;
  localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));

  seq_state_e state_q;
  seq_state_e state_nxt;
  mode_e      mode_c;

  logic [DIV_W-1:0]         cnt_q;
  logic [DIV_W-1:0]         lim_q;
  logic                     tick_c;
  logic                     run_tick_c;

  logic [DATA_W-1:0]        ramp_q;
  logic [DATA_W-1:0]        ramp_nxt;
  logic [NUM_CH*DATA_W-1:0] dac_q;
  logic [NUM_CH*DATA_W-1:0] dac_nxt;
  logic [NUM_CH-1:0]        upd_q;
  logic [NUM_CH-1:0]        upd_nxt;
  logic                     underrun_q;
  logic                     err_ch_q;
  logic                     underrun_set_c;
  logic                     err_set_c;

  logic                     push_c;
  logic                     pop_c;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ENT_W-1:0]         rd_ent;
  logic [CH_W-1:0]          rd_ch;
  logic [DATA_W-1:0]        rd_code;
  logic [LVL_W-1:0]         level;

  assign mode_c    = mode_e'(mode);
  assign s_ready   = !fifo_full;
  assign push_c    = s_valid && s_ready;
  // Widened compare keeps the check meaningful when NUM_CH is a power of two.
  assign err_set_c = push_c && (32'(s_ch) >= NUM_CH);

  sync_fifo_fl #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (reset_n),
    .flush   (flush),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data ({s_ch, s_data}),
    .rd_data (rd_ent),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign rd_ch   = rd_ent[ENT_W-1 -: CH_W];
  assign rd_code = rd_ent[DATA_W-1:0];

  // Sequencer state register.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; dropping enable returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_nxt = ST_PRIME;
      ST_PRIME: if ((32'(level) >= PRIME_LVL) || (mode_c != MODE_STREAM)) state_nxt = ST_RUN;
      ST_RUN:   if (flush) state_nxt = ST_PRIME;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!enable) state_nxt = ST_IDLE;
  end

  // Rate divider; the limit is re-sampled only on wrap or while idle.
  assign tick_c     = (state_q != ST_IDLE) && (cnt_q == lim_q);
  assign run_tick_c = tick_c && enable && (state_q == ST_RUN);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else if ((state_q == ST_IDLE) || tick_c) begin
      cnt_q <= '0;
      lim_q <= rate_div;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

  // Tick actions: next channel codes, strobes, ramp and FIFO pop.
  always_comb begin
    dac_nxt        = dac_q;
    upd_nxt        = '0;
    ramp_nxt       = ramp_q;
    pop_c          = 1'b0;
    underrun_set_c = 1'b0;
    if (run_tick_c) begin
      case (mode_c)
        MODE_STREAM: begin
          if (fifo_empty) begin
            underrun_set_c = 1'b1;
          end else if (!flush) begin
            pop_c = 1'b1;
            // Illegal-channel entries match no channel and are simply discarded.
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (32'(rd_ch) == i) begin
                dac_nxt[i*DATA_W +: DATA_W] = rd_code;
                upd_nxt[i]                  = 1'b1;
              end
            end
          end
        end
        MODE_HOLD: begin
        end
        MODE_MUTE: begin
          dac_nxt = {NUM_CH{MID}};
          upd_nxt = '1;
        end
        MODE_RAMP: begin
          dac_nxt  = {NUM_CH{ramp_q}};
          upd_nxt  = '1;
          ramp_nxt = ramp_q + DATA_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Output and sticky-flag registers; a same-cycle set beats err_clr.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      dac_q      <= {NUM_CH{MID}};
      upd_q      <= '0;
      ramp_q     <= '0;
      underrun_q <= 1'b0;
      err_ch_q   <= 1'b0;
    end else begin
      dac_q      <= dac_nxt;
      upd_q      <= upd_nxt;
      ramp_q     <= ramp_nxt;
      underrun_q <= underrun_set_c || (underrun_q && !err_clr);
      err_ch_q   <= err_set_c || (err_ch_q && !err_clr);
    end
  end

  assign dac_d      = dac_q;
  assign dac_upd    = upd_q;
  assign fifo_level = level;
  assign underrun   = underrun_q;
  assign err_ch     = err_ch_q;

endmodule

// File: tb/tb_dac_stream_sequencer.sv
// Directed bench for dac_stream_sequencer: scoreboard for streamed samples, small
// models for ramp and mute, direct checks on flags, levels and reset.
module tb_dac_stream_sequencer;

  localparam int unsigned DATA_W     = 10;
  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned PRIME_LVL  = 4;
  localparam int unsigned CH_W       = 2;
  localparam int unsigned LVL_W      = 4;
  localparam logic [DATA_W-1:0] MID  = 10'h200;

  localparam int CK_NONE   = 0;
  localparam int CK_STREAM = 1;
  localparam int CK_RAMP   = 2;
  localparam int CK_MUTE   = 3;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_W-1:0]        s_data;
  logic [CH_W-1:0]          s_ch;
  logic                     enable;
  logic [1:0]               mode;
  logic [DIV_W-1:0]         rate_div;
  logic                     flush;
  logic                     err_clr;
  logic [NUM_CH*DATA_W-1:0] dac_d;
  logic [NUM_CH-1:0]        dac_upd;
  logic [LVL_W-1:0]         fifo_level;
  logic                     underrun;
  logic                     err_ch;

  exp_t              exp_q[$];
  int                upd_t[$];
  int                n_chk;
  int                n_fail;
  int                cyc_n;
  int                chk_mode;
  int                n_ramp;
  int                ramp_last;
  int                n_mute;
  int                acc;
  logic [DATA_W-1:0] ramp_exp;

  dac_stream_sequencer #(
    .DATA_W     (DATA_W),
    .NUM_CH     (NUM_CH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W),
    .PRIME_LVL  (PRIME_LVL)
  ) dut (
    .CLK        (clk),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_ch       (s_ch),
    .enable     (enable),
    .mode       (mode),
    .rate_div   (rate_div),
    .flush      (flush),
    .err_clr    (err_clr),
    .dac_d      (dac_d),
    .dac_upd    (dac_upd),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .err_ch     (err_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ch_code(input int i);
    return dac_d[i*DATA_W +: DATA_W];
  endfunction

  // Called once per cycle at the falling edge; checks any strobe against the active model.
  task automatic monitor();
    exp_t e;
    if (dac_upd === '0) return;
    case (chk_mode)
      CK_STREAM: begin
        upd_t.push_back(cyc_n);
        if (exp_q.size() == 0) begin
          check("stream_unexpected_upd", 64'(dac_upd), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("stream_upd_mask", 64'(dac_upd), 64'(64'd1 << e.ch));
          check("stream_code", 64'(ch_code(int'(e.ch))), 64'(e.data));
        end
      end
      CK_RAMP: begin
        check("ramp_upd_mask", 64'(dac_upd), 64'(3'b111));
        for (int i = 0; i < int'(NUM_CH); i++) check("ramp_code", 64'(ch_code(i)), 64'(ramp_exp));
        if (ramp_last >= 0) check("ramp_gap", 64'(cyc_n - ramp_last), 64'(1));
        if (n_ramp == 1024) check("ramp_wrap", 64'(ch_code(0)), 64'(0));
        ramp_last = cyc_n;
        ramp_exp  = ramp_exp + DATA_W'(1);
        n_ramp++;
      end
      CK_MUTE: begin
        check("mute_upd_mask", 64'(dac_upd), 64'(3'b111));
        check("mute_code", 64'(dac_d), 64'({NUM_CH{MID}}));
        n_mute++;
      end
      default: begin
      end
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc_n++;
    monitor();
  endtask

  task automatic push(input int ch, input int data, input bit to_sb);
    exp_t e;
    s_valid = 1'b1;
    s_ch    = CH_W'(ch);
    s_data  = DATA_W'(data);
    if (s_ready && to_sb) begin
      e.ch   = CH_W'(ch);
      e.data = DATA_W'(data);
      exp_q.push_back(e);
    end
    cycle();
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) cycle();
    check("drain_complete", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc_n = 0; chk_mode = CK_NONE;
    n_ramp = 0; ramp_last = -1; n_mute = 0; ramp_exp = '0; acc = 0;
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_ch = '0; enable = 1'b0;
    mode = 2'd0; rate_div = DIV_W'(3); flush = 1'b0; err_clr = 1'b0;

    repeat (3) cycle();
    check("reset_dac_d", 64'(dac_d), 64'({NUM_CH{MID}}));
    check("reset_dac_upd", 64'(dac_upd), 64'(0));
    check("reset_s_ready", 64'(s_ready), 64'(1));
    check("reset_level", 64'(fifo_level), 64'(0));
    check("reset_underrun", 64'(underrun), 64'(0));
    check("reset_err_ch", 64'(err_ch), 64'(0));
    reset_n = 1'b1;
    cycle();

    // Prime then stream four alternating samples at rate_div=3.
    chk_mode = CK_STREAM;
    enable   = 1'b1;
    push(0, 'h010, 1'b1);
    push(1, 'h011, 1'b1);
    push(0, 'h012, 1'b1);
    repeat (8) cycle();
    check("prime_level", 64'(fifo_level), 64'(3));
    check("prime_no_upd", 64'(upd_t.size()), 64'(0));
    push(1, 'h013, 1'b1);
    wait_drain(64);
    check("stream_upd_count", 64'(upd_t.size()), 64'(4));
    for (int i = 1; i < upd_t.size(); i++) check("stream_upd_gap", 64'(upd_t[i] - upd_t[i-1]), 64'(4));

    // Empty FIFO in RUN/STREAM: underrun on next tick, codes held.
    repeat (6) cycle();
    check("underrun_set", 64'(underrun), 64'(1));
    check("underrun_dac_held", 64'(dac_d), 64'({MID, 10'h013, 10'h012}));
    enable = 1'b0;
    cycle();
    pulse_err_clr();
    check("underrun_cleared", 64'(underrun), 64'(0));

    // Fill with sequencer disabled: eight accepted, ninth refused.
    upd_t.delete();
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      if (s_ready) acc++;
      push(i % 2, 'h100 + i, 1'b1);
    end
    check("fill_accepted", 64'(acc), 64'(8));
    check("fill_level", 64'(fifo_level), 64'(8));
    check("fill_s_ready", 64'(s_ready), 64'(0));
    enable = 1'b1;
    wait_drain(100);
    check("drain_level", 64'(fifo_level), 64'(0));
    check("drain_s_ready", 64'(s_ready), 64'(1));
    enable = 1'b0;
    cycle();
    pulse_err_clr();

    // Flush empties the FIFO and discards a same-cycle push.
    push(0, 'h3AA, 1'b0);
    push(1, 'h3AB, 1'b0);
    check("preflush_level", 64'(fifo_level), 64'(2));
    flush = 1'b1; s_valid = 1'b1; s_ch = '0; s_data = 10'h3AC;
    cycle();
    flush = 1'b0; s_valid = 1'b0;
    check("flush_level", 64'(fifo_level), 64'(0));

    // Illegal channel: flag set, entry occupies a slot, popped with no strobe.
    push(3, 'h155, 1'b0);
    check("err_ch_set", 64'(err_ch), 64'(1));
    push(0, 'h0AA, 1'b1);
    push(1, 'h0BB, 1'b1);
    push(0, 'h0CC, 1'b1);
    check("err_level", 64'(fifo_level), 64'(4));
    err_clr = 1'b1;
    push(3, 'h156, 1'b0);
    err_clr = 1'b0;
    check("err_set_beats_clr", 64'(err_ch), 64'(1));
    enable = 1'b1;
    wait_drain(100);
    repeat (8) cycle();
    check("err_drain_level", 64'(fifo_level), 64'(0));
    check("err_dac_d", 64'(dac_d), 64'({MID, 10'h0BB, 10'h0CC}));
    enable = 1'b0;
    cycle();
    pulse_err_clr();
    check("err_ch_cleared", 64'(err_ch), 64'(0));

    // Ramp every cycle through the 10-bit wrap.
    chk_mode = CK_RAMP; mode = 2'd3; rate_div = '0; ramp_exp = '0; n_ramp = 0; ramp_last = -1;
    enable = 1'b1;
    for (int i = 0; i < 1300 && n_ramp < 1030; i++) cycle();
    enable = 1'b0;
    cycle();
    check("ramp_event_count", 64'(n_ramp >= 1030), 64'(1));

    // Mute forces midscale on every tick.
    chk_mode = CK_MUTE; mode = 2'd2; rate_div = DIV_W'(1); n_mute = 0;
    enable = 1'b1;
    repeat (12) cycle();
    enable = 1'b0;
    cycle();
    check("mute_event_count", 64'(n_mute >= 4), 64'(1));

    // Asynchronous reset in the middle of a ramp run.
    chk_mode = CK_NONE; mode = 2'd3; rate_div = '0;
    push(3, 'h001, 1'b0);
    enable = 1'b1;
    repeat (10) cycle();
    #2 reset_n = 1'b0;
    #1;
    check("midrun_reset_dac_d", 64'(dac_d), 64'({NUM_CH{MID}}));
    check("midrun_reset_upd", 64'(dac_upd), 64'(0));
    check("midrun_reset_level", 64'(fifo_level), 64'(0));
    check("midrun_reset_err_ch", 64'(err_ch), 64'(0));
    enable = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    chk_mode = CK_RAMP; ramp_exp = '0; n_ramp = 0; ramp_last = -1;
    enable = 1'b1;
    repeat (8) cycle();
    enable = 1'b0;
    cycle();
    check("post_reset_ramp_events", 64'(n_ramp >= 4), 64'(1));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
